// File: rtl/crack_pkg.sv
// crack_pkg: shared state encoding, key width and printable-ASCII window
// for the ARC4 key-search controller.
package crack_pkg;
    localparam int KEY_W = 24;
    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    typedef enum logic [2:0] {IDLE, ARM, FIRE, RUN, LEN_RD, LEN_CAP, SCAN, NEXT} state_t;

    function automatic logic is_print(input logic [7:0] b);
        return b >= ASCII_LO && b <= ASCII_HI;
    endfunction
endpackage

// File: rtl/pt_port_mux.sv
// pt_port_mux: hands the pt_mem port to the controller (read-only) or to arc4.
module pt_port_mux (
    input  logic       sel,
    input  logic [7:0] ctrl_addr,
    input  logic [7:0] a4_addr,
    input  logic [7:0] a4_wrdata,
    input  logic       a4_wren,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);
    assign pt_addr   = sel ? ctrl_addr : a4_addr;
    assign pt_wrdata = sel ? 8'd0 : a4_wrdata;
    assign pt_wren   = !sel && a4_wren;
endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: steps one arc4 core over a key range and reports the first
// key whose decrypted message is entirely printable ASCII.
module key_search_ctrl
    import crack_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_START  = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_STRIDE = 24'h000001,
    parameter logic [KEY_W-1:0] KEY_LAST   = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic             stop,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_out,
    output logic             a4_en,
    input  logic             a4_rdy,
    output logic [KEY_W-1:0] a4_key,
    input  logic [7:0]       a4_pt_addr,
    input  logic [7:0]       a4_pt_wrdata,
    input  logic             a4_pt_wren,
    output logic [7:0]       pt_addr,
    output logic [7:0]       pt_wrdata,
    output logic             pt_wren,
    input  logic [7:0]       pt_rddata
);
    state_t state, state_n;
    logic [KEY_W-1:0] key;
    logic [KEY_W:0] key_nxt;
    logic [7:0] len, ctrl_addr;
    logic [8:0] idx, idx_m1;
    logic run_first, ctrl_sel, bad, last, done;

    assign key_nxt   = {1'b0, key} + {1'b0, KEY_STRIDE};
    assign done      = stop || key == KEY_LAST || key_nxt > {1'b0, KEY_LAST};
    assign idx_m1    = idx - 9'd1;
    // byte idx-1 arrives this cycle; idx=1 has nothing in flight yet
    assign bad       = state == SCAN && idx >= 9'd2 && !is_print(pt_rddata);
    assign last      = idx == {1'b0, len} + 9'd1;
    // hold the address on the final/failing cycle so it never runs past len
    assign ctrl_addr = state != SCAN ? 8'd0 : (bad || last) ? idx_m1[7:0] : idx[7:0];
    assign ctrl_sel  = state inside {LEN_RD, LEN_CAP, SCAN};
    assign rdy       = state == IDLE;
    assign a4_en     = state == FIRE;

    pt_port_mux u_mux (
        .sel(ctrl_sel), .ctrl_addr(ctrl_addr), .a4_addr(a4_pt_addr),
        .a4_wrdata(a4_pt_wrdata), .a4_wren(a4_pt_wren),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (en) state_n = ARM;
            ARM:     if (a4_rdy) state_n = FIRE;
            FIRE:    state_n = RUN;
            RUN:     if (!run_first && a4_rdy) state_n = LEN_RD;
            LEN_RD:  state_n = LEN_CAP;
            LEN_CAP: state_n = pt_rddata == 8'd0 ? IDLE : SCAN;
            SCAN:    state_n = bad ? NEXT : last ? IDLE : SCAN;
            NEXT:    state_n = done ? IDLE : ARM;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            key       <= KEY_START;
            key_out   <= '0;
            key_valid <= 1'b0;
            a4_key    <= '0;
            len       <= 8'd0;
            idx       <= 9'd0;
            run_first <= 1'b0;
        end else begin
            if (state == IDLE && en) begin
                key       <= KEY_START;
                key_valid <= 1'b0;
            end
            if (state == ARM && a4_rdy) a4_key <= key;
            run_first <= state == FIRE;
            if (state == LEN_CAP) begin
                len <= pt_rddata;
                idx <= 9'd1;
            end
            if (state == SCAN && !bad) idx <= idx + 9'd1;
            if ((state == LEN_CAP && pt_rddata == 8'd0) || (state == SCAN && !bad && last)) begin
                key_out   <= key;
                key_valid <= 1'b1;
            end
            if (state == NEXT && !done) key <= key_nxt[KEY_W-1:0];
        end
endmodule
